// File: rtl/regfile_pkg.sv
// regfile_pkg: shared core constants and types for the integer register file
// Contents: XLEN / REG_ADDR_W widths, xlen_t / reg_addr_t typedefs, ZERO_REG address
package regfile_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
    localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/regfile.sv
// regfile: 2**ADDR_W x DATA_W register file, two combinational reads, one synchronous write, x0 = 0
// Ports: clk, rst_n (async, active low, clears all), we3/a3/wd3 write port,
//        a1 -> rd1 and a2 -> rd2 combinational read ports (no write bypass)
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);
    logic [DATA_W-1:0] regs [2**ADDR_W];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        else if (we3 && a3 != '0)
            regs[a3] <= wd3;

    // x0 masked on read so entry 0 never matters
    assign rd1 = (a1 == '0) ? '0 : regs[a1];
    assign rd2 = (a2 == '0) ? '0 : regs[a2];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: self-checking bench for regfile against an array reference model
module tb_regfile;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        we3 = 0;
    logic [4:0]  a1 = 0, a2 = 0, a3 = 0;
    logic [31:0] wd3 = 0;
    logic [31:0] rd1, rd2;
    logic [31:0] m [32];
    int tests = 0;
    int fails = 0;

    regfile dut (
        .clk(clk), .rst_n(rst_n), .we3(we3),
        .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
        .rd1(rd1), .rd2(rd2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        return (a == 0) ? 32'h0 : m[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
    endtask

    task automatic edge_write();
        @(posedge clk);
        if (rst_n && we3 && a3 != 0) m[a3] = wd3;
        #1;
    endtask

    task automatic test_reset();
        clear_model();
        rst_n = 0;
        @(negedge clk);
        we3 = 1; a3 = 5'd3; wd3 = 32'hcafef00d; a1 = 5'd3; a2 = 5'd3;
        @(posedge clk); #1;
        tests++;
        if (rd1 !== 32'h0) begin fails++; $display("FAIL reset_write_ignored rd1=%h exp=%h", rd1, 32'h0); end
        @(negedge clk);
        we3 = 0;
        rst_n = 1;
        for (int i = 1; i < 32; i++) begin
            a1 = i[4:0]; a2 = 5'(32 - i);
            #1;
            tests++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                fails++; $display("FAIL reset_read a1=%0d rd1=%h a2=%0d rd2=%h exp=0", a1, rd1, a2, rd2);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        a3 = 5'd1; wd3 = 32'hffff5555; we3 = 1;
        edge_write();
        @(negedge clk);
        we3 = 0; a1 = 5'd1;
        #1;
        tests++;
        if (rd1 !== 32'hffff5555) begin fails++; $display("FAIL write_read rd1=%h exp=%h", rd1, 32'hffff5555); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        a3 = 5'd0; wd3 = 32'hffffaaaa; we3 = 1;
        edge_write();
        @(negedge clk);
        we3 = 0; a1 = 5'd0; a2 = 5'd0;
        #1;
        tests++;
        if (rd2 !== 32'h0) begin fails++; $display("FAIL x0_rd2 rd2=%h exp=%h", rd2, 32'h0); end
        tests++;
        if (rd1 !== 32'h0) begin fails++; $display("FAIL x0_rd1 rd1=%h exp=%h", rd1, 32'h0); end
    endtask

    task automatic test_dual_port();
        a1 = 5'd1; a2 = 5'd0;
        #1;
        tests++;
        if (rd1 !== 32'hffff5555 || rd2 !== 32'h0) begin
            fails++; $display("FAIL dual_mixed rd1=%h rd2=%h exp=%h/%h", rd1, rd2, 32'hffff5555, 32'h0);
        end
        a2 = 5'd1;
        #1;
        tests++;
        if (rd1 !== 32'hffff5555 || rd2 !== 32'hffff5555) begin
            fails++; $display("FAIL dual_same rd1=%h rd2=%h exp=%h", rd1, rd2, 32'hffff5555);
        end
    endtask

    task automatic test_we_low_rdw();
        @(negedge clk);
        we3 = 0; a3 = 5'd1; wd3 = 32'h12345678; a1 = 5'd1;
        edge_write();
        tests++;
        if (rd1 !== 32'hffff5555) begin fails++; $display("FAIL we_low rd1=%h exp=%h", rd1, 32'hffff5555); end
        @(negedge clk);
        we3 = 1;
        #1;
        tests++;
        if (rd1 !== 32'hffff5555) begin fails++; $display("FAIL rdw_before rd1=%h exp=%h", rd1, 32'hffff5555); end
        edge_write();
        tests++;
        if (rd1 !== 32'h12345678) begin fails++; $display("FAIL rdw_after rd1=%h exp=%h", rd1, 32'h12345678); end
        @(negedge clk);
        we3 = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we3 = 1'($urandom_range(0, 1));
            a3  = 5'($urandom_range(0, 31));
            wd3 = $urandom;
            a1  = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            a2  = 5'($urandom_range(0, 31));
            #1;
            tests++;
            if (rd1 !== ref_rd(a1) || rd2 !== ref_rd(a2)) begin
                fails++; $display("FAIL rand_pre n=%0d a1=%0d rd1=%h exp=%h a2=%0d rd2=%h exp=%h",
                                  n, a1, rd1, ref_rd(a1), a2, rd2, ref_rd(a2));
            end
            edge_write();
            tests++;
            if (rd1 !== ref_rd(a1) || rd2 !== ref_rd(a2)) begin
                fails++; $display("FAIL rand_post n=%0d a1=%0d rd1=%h exp=%h a2=%0d rd2=%h exp=%h",
                                  n, a1, rd1, ref_rd(a1), a2, rd2, ref_rd(a2));
            end
        end
        @(negedge clk);
        we3 = 0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a3 = 5'd5; wd3 = 32'hdeadbeef; we3 = 1; a1 = 5'd5; a2 = 5'd7;
        edge_write();
        we3 = 0;
        tests++;
        if (rd1 !== 32'hdeadbeef) begin fails++; $display("FAIL async_pre rd1=%h exp=%h", rd1, 32'hdeadbeef); end
        #2;
        rst_n = 0;
        clear_model();
        #1;
        tests++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            fails++; $display("FAIL async_reset rd1=%h rd2=%h exp=0", rd1, rd2);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 1; i < 32; i++) begin
            a1 = i[4:0];
            #1;
            tests++;
            if (rd1 !== ref_rd(a1)) begin fails++; $display("FAIL async_clear a1=%0d rd1=%h exp=%h", a1, rd1, ref_rd(a1)); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_dual_port();
        test_we_low_rdw();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
